// File: rtl/ikaopm_timing_pkg.sv
// ikaopm_timing_pkg: OPM timing defaults, named tap compare values and a
// helper that packs a tap value into the i_TAP_CFG vector.
package ikaopm_timing_pkg;

  // Default OPM frame geometry and pipeline depths.
  localparam int OPM_SLOTS       = 32;
  localparam int OPM_SLOT_W      = 5;
  localparam int OPM_CEN_DIV     = 2;
  localparam int OPM_SYNC_STAGES = 4;
  localparam int OPM_SH_DELAY    = 5;
  localparam int OPM_TAP_NUM     = 16;

  // Named tap compare values; a tap fires in the slot after its compare value.
  localparam logic [OPM_SLOT_W-1:0] TAP_CYCLE_01 = OPM_SLOT_W'(0);
  localparam logic [OPM_SLOT_W-1:0] TAP_CYCLE_12 = OPM_SLOT_W'(11);
  localparam logic [OPM_SLOT_W-1:0] TAP_CYCLE_28 = OPM_SLOT_W'(27);
  localparam logic [OPM_SLOT_W-1:0] TAP_CYCLE_31 = OPM_SLOT_W'(30);

  // A pair of taps that are always used together.
  typedef struct packed {
    logic [OPM_SLOT_W-1:0] first;
    logic [OPM_SLOT_W-1:0] second;
  } tap_pair_t;

  localparam tap_pair_t TAP_CYCLE_12_28 = '{first: TAP_CYCLE_12, second: TAP_CYCLE_28};

  // Full tap configuration vector for the default geometry.
  typedef logic [OPM_TAP_NUM*OPM_SLOT_W-1:0] opm_tap_cfg_t;

  // Returns cfg with tap idx replaced by value.
  function automatic opm_tap_cfg_t opm_set_tap(input opm_tap_cfg_t cfg,
                                               input int unsigned idx,
                                               input logic [OPM_SLOT_W-1:0] value);
    opm_tap_cfg_t result;
    result = cfg;
    result[idx*OPM_SLOT_W +: OPM_SLOT_W] = value;
    return result;
  endfunction

endpackage

// File: rtl/ikaopm_cen_divider.sv
// ikaopm_cen_divider: reset-release synchroniser, run flag, phi1 phase counter
// and the phi1 rising/falling clock enables derived from the phiM enable.
module ikaopm_cen_divider
  import ikaopm_timing_pkg::*;
#(
  parameter int CEN_DIV     = OPM_CEN_DIV,
  parameter int SYNC_STAGES = OPM_SYNC_STAGES
) (
  input  logic i_EMUCLK,
  input  logic i_IC_n,
  input  logic i_phiM_PCEN_n,
  output logic o_run,
  output logic o_phi1,
  output logic o_phi1_PCEN_n,
  output logic o_phi1_NCEN_n
);

  localparam int PH_W = $clog2(CEN_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CEN_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CEN_DIV / 2);
  localparam logic [PH_W-1:0] PH_NEG  = PH_W'(CEN_DIV / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [PH_W-1:0]        ph_q;
  logic                   phim_en;

  assign phim_en = ~i_phiM_PCEN_n;
  assign o_run   = sync_q[SYNC_STAGES-1];

  // Release synchroniser: fills with ones on phiM enables after reset lifts.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) sync_q <= '0;
    else if (phim_en) sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Phase counter cycles 0..CEN_DIV-1 on phiM enables once running.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) ph_q <= '0;
    else if (phim_en && o_run) ph_q <= (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
  end

  // Enables decode combinationally so they coincide with their phiM enable.
  always_comb begin
    o_phi1        = (ph_q < PH_HALF);
    o_phi1_PCEN_n = ~(phim_en & o_run & (ph_q == PH_LAST));
    o_phi1_NCEN_n = ~(phim_en & o_run & (ph_q == PH_NEG));
  end

endmodule

// File: rtl/ikaopm_slotgen.sv
// ikaopm_slotgen: slot-timing generator for the FM core. Divides phiM into
// phi1, counts slots, and produces tap decode, SH1/SH2 and frame strobes.
// Optional frame-resync handshake enabled by IKAOPM_SLOTGEN_RESYNC_EN.
module ikaopm_slotgen
  import ikaopm_timing_pkg::*;
#(
  parameter int SLOTS       = OPM_SLOTS,
  parameter int SLOT_W      = OPM_SLOT_W,
  parameter int CEN_DIV     = OPM_CEN_DIV,
  parameter int SYNC_STAGES = OPM_SYNC_STAGES,
  parameter int SH_DELAY    = OPM_SH_DELAY,
  parameter int TAP_NUM     = OPM_TAP_NUM
) (
  input  logic                      i_EMUCLK,
  input  logic                      i_IC_n,
  input  logic                      i_phiM_PCEN_n,
  input  logic [TAP_NUM*SLOT_W-1:0] i_TAP_CFG,
  input  logic                      i_SYNC_REQ,
  output logic                      o_SYNC_ACK,
  output logic                      o_MRST_n,
  output logic                      o_phi1,
  output logic                      o_phi1_PCEN_n,
  output logic                      o_phi1_NCEN_n,
  output logic [SLOT_W-1:0]         o_SLOT,
  output logic [TAP_NUM-1:0]        o_TAP,
  output logic                      o_SH1,
  output logic                      o_SH2,
  output logic                      o_FRAME
);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [SLOT_W-1:0] SH1_LO    = SLOT_W'(SLOTS / 4);
  localparam logic [SLOT_W-1:0] SH1_HI    = SLOT_W'(SLOTS / 2);
  localparam logic [SLOT_W-1:0] SH2_LO    = SLOT_W'(3 * SLOTS / 4);

  logic                run;
  logic                ncen;
  logic                resync_load;
  logic [TAP_NUM-1:0]  tap_hit;
  logic                sh1_raw;
  logic                sh2_raw;
  logic [SH_DELAY-1:0] sh1_pipe;
  logic [SH_DELAY-1:0] sh2_pipe;

  ikaopm_cen_divider #(
    .CEN_DIV     (CEN_DIV),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cen_divider (
    .i_EMUCLK      (i_EMUCLK),
    .i_IC_n        (i_IC_n),
    .i_phiM_PCEN_n (i_phiM_PCEN_n),
    .o_run         (run),
    .o_phi1        (o_phi1),
    .o_phi1_PCEN_n (o_phi1_PCEN_n),
    .o_phi1_NCEN_n (o_phi1_NCEN_n)
  );

  assign ncen = ~o_phi1_NCEN_n;

`ifdef IKAOPM_SLOTGEN_RESYNC_EN
  logic sync_ack_q;

  assign resync_load = i_SYNC_REQ & ~sync_ack_q & o_MRST_n;
  assign o_SYNC_ACK  = sync_ack_q;

  // Four-phase handshake: acknowledge a load, release once the request drops.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) sync_ack_q <= 1'b0;
    else if (ncen) begin
      if (resync_load) sync_ack_q <= 1'b1;
      else if (!i_SYNC_REQ) sync_ack_q <= 1'b0;
    end
  end
`else
  logic unused_sync_req;

  assign unused_sync_req = i_SYNC_REQ;
  assign resync_load     = 1'b0;
  assign o_SYNC_ACK      = 1'b0;
`endif

  // Core reset follows run; the slot counter stays at 0 until the core is out of reset.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      o_MRST_n <= 1'b0;
      o_SLOT   <= '0;
    end else if (ncen) begin
      o_MRST_n <= run;
      if (!o_MRST_n || resync_load) o_SLOT <= '0;
      else if (o_SLOT == SLOT_LAST) o_SLOT <= '0;
      else o_SLOT <= o_SLOT + SLOT_W'(1);
    end
  end

  // Slot decode; qualified by MRST so the held startup slot is not counted as slot 0.
  always_comb begin
    tap_hit = '0;
    for (int k = 0; k < TAP_NUM; k++) begin
      tap_hit[k] = o_MRST_n
                && (o_SLOT == i_TAP_CFG[k*SLOT_W +: SLOT_W])
                && (int'(i_TAP_CFG[k*SLOT_W +: SLOT_W]) < SLOTS);
    end
    sh1_raw = (o_SLOT >= SH1_LO) && (o_SLOT < SH1_HI);
    sh2_raw = (o_SLOT >= SH2_LO);
  end

  // Registered decode strobes, one phi1 behind the slot counter.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      o_TAP   <= '0;
      o_FRAME <= 1'b0;
    end else if (ncen) begin
      o_TAP   <= tap_hit;
      o_FRAME <= o_MRST_n && (o_SLOT == SLOT_LAST);
    end
  end

  // SH delay lines; the final stage is masked so nothing leaks out during core reset.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      sh1_pipe <= '0;
      sh2_pipe <= '0;
      o_SH1    <= 1'b0;
      o_SH2    <= 1'b0;
    end else if (ncen) begin
      sh1_pipe[0] <= sh1_raw;
      sh2_pipe[0] <= sh2_raw;
      for (int j = 1; j < SH_DELAY; j++) begin
        sh1_pipe[j] <= sh1_pipe[j-1];
        sh2_pipe[j] <= sh2_pipe[j-1];
      end
      o_SH1 <= sh1_pipe[SH_DELAY-1] & o_MRST_n;
      o_SH2 <= sh2_pipe[SH_DELAY-1] & o_MRST_n;
    end
  end

endmodule

// File: tb/tb_ikaopm_slotgen.sv
// tb_ikaopm_slotgen: two slot generators (OPM defaults, and a 24-slot
// divide-by-6 variant) driven with random phiM enables and resync requests,
// compared every EMUCLK against an enable-count model of the timing rules.
module tb_ikaopm_slotgen;
  import ikaopm_timing_pkg::*;

`ifdef IKAOPM_SLOTGEN_RESYNC_EN
  localparam bit RESYNC_EN = 1'b1;
`else
  localparam bit RESYNC_EN = 1'b0;
`endif
  localparam int SH_D = 5;

  logic clk = 1'b0;
  logic icN = 1'b0;
  logic pcenN = 1'b1;
  logic syncReq = 1'b0;

  opm_tap_cfg_t cfgA;
  logic [14:0]  cfgB;

  logic        oAck  [2];
  logic        oMrst [2];
  logic        oPhi1 [2];
  logic        oPcen [2];
  logic        oNcen [2];
  logic [4:0]  oSlot [2];
  logic [15:0] oTap  [2];
  logic [2:0]  tapB;
  logic        oSh1  [2];
  logic        oSh2  [2];
  logic        oFrame[2];

  int checks = 0;
  int failures = 0;

  // Reference model state, indexed by instance.
  int          mSlots[2] = '{32, 24};
  int          mDiv  [2] = '{2, 6};
  int          mSS   [2] = '{4, 3};
  int          mTapN [2] = '{16, 3};
  int          tapVal[2][16];
  int          enCnt [2];
  int          nCnt  [2];
  bit          mMrst [2];
  int          mSlot [2];
  bit          mAck  [2];
  logic [15:0] mTap  [2];
  bit          mFrame[2];
  bit          mSh1  [2];
  bit          mSh2  [2];
  bit          h1[2][64];
  bit          h2[2][64];

  always #5 clk = ~clk;

  ikaopm_slotgen dutA (
    .i_EMUCLK(clk), .i_IC_n(icN), .i_phiM_PCEN_n(pcenN), .i_TAP_CFG(cfgA),
    .i_SYNC_REQ(syncReq), .o_SYNC_ACK(oAck[0]), .o_MRST_n(oMrst[0]),
    .o_phi1(oPhi1[0]), .o_phi1_PCEN_n(oPcen[0]), .o_phi1_NCEN_n(oNcen[0]),
    .o_SLOT(oSlot[0]), .o_TAP(oTap[0]), .o_SH1(oSh1[0]), .o_SH2(oSh2[0]),
    .o_FRAME(oFrame[0])
  );

  ikaopm_slotgen #(
    .SLOTS(24), .SLOT_W(5), .CEN_DIV(6), .SYNC_STAGES(3), .SH_DELAY(5), .TAP_NUM(3)
  ) dutB (
    .i_EMUCLK(clk), .i_IC_n(icN), .i_phiM_PCEN_n(pcenN), .i_TAP_CFG(cfgB),
    .i_SYNC_REQ(syncReq), .o_SYNC_ACK(oAck[1]), .o_MRST_n(oMrst[1]),
    .o_phi1(oPhi1[1]), .o_phi1_PCEN_n(oPcen[1]), .o_phi1_NCEN_n(oNcen[1]),
    .o_SLOT(oSlot[1]), .o_TAP(tapB), .o_SH1(oSh1[1]), .o_SH2(oSh2[1]),
    .o_FRAME(oFrame[1])
  );

  assign oTap[1] = {13'b0, tapB};

  task automatic checkOutput(input string tag, input int inst,
                             input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s[%0d] observed=%0h expected=%0h at %0t", tag, inst, observed, expected, $time);
      $error("[TB] check %s[%0d] differs", tag, inst);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      enCnt[i] = 0; nCnt[i] = 0; mMrst[i] = 0; mSlot[i] = 0; mAck[i] = 0;
      mTap[i] = '0; mFrame[i] = 0; mSh1[i] = 0; mSh2[i] = 0;
      for (int j = 0; j < 64; j++) begin
        h1[i][j] = 0;
        h2[i][j] = 0;
      end
    end
  endtask

  // One phi1 falling enable: every registered output steps from the pre-edge slot.
  task automatic modelNcen(input int i);
    bit prevMrst;
    int prev;
    bit load;
    prevMrst = mMrst[i];
    prev = mSlot[i];
    load = RESYNC_EN && syncReq && !mAck[i] && prevMrst;
    for (int k = 0; k < 16; k++)
      mTap[i][k] = (k < mTapN[i]) && prevMrst && (tapVal[i][k] < mSlots[i]) && (prev == tapVal[i][k]);
    mFrame[i] = prevMrst && (prev == mSlots[i] - 1);
    nCnt[i]++;
    h1[i][nCnt[i] % 64] = (prev >= mSlots[i] / 4) && (prev < mSlots[i] / 2);
    h2[i][nCnt[i] % 64] = (prev >= 3 * mSlots[i] / 4);
    mSh1[i] = prevMrst && (nCnt[i] > SH_D) && h1[i][(nCnt[i] - SH_D) % 64];
    mSh2[i] = prevMrst && (nCnt[i] > SH_D) && h2[i][(nCnt[i] - SH_D) % 64];
    if (!prevMrst || load) mSlot[i] = 0;
    else mSlot[i] = (prev + 1) % mSlots[i];
    if (load) mAck[i] = 1;
    else if (!syncReq) mAck[i] = 0;
    mMrst[i] = 1;
  endtask

  // One EMUCLK edge out of reset: count phiM enables, fire NCEN at its phase.
  task automatic modelEdge();
    for (int i = 0; i < 2; i++) begin
      if (!pcenN) begin
        if (enCnt[i] >= mSS[i] && ((enCnt[i] - mSS[i]) % mDiv[i]) == mDiv[i] / 2 - 1)
          modelNcen(i);
        enCnt[i]++;
      end
    end
  endtask

  task automatic checkComb();
    for (int i = 0; i < 2; i++) begin
      bit run;
      int ph;
      run = enCnt[i] >= mSS[i];
      ph = run ? (enCnt[i] - mSS[i]) % mDiv[i] : 0;
      checkOutput("phi1", i, 32'(oPhi1[i]), 32'(ph < mDiv[i] / 2));
      checkOutput("pcen_n", i, 32'(oPcen[i]), 32'(!(!pcenN && run && ph == mDiv[i] - 1)));
      checkOutput("ncen_n", i, 32'(oNcen[i]), 32'(!(!pcenN && run && ph == mDiv[i] / 2 - 1)));
    end
  endtask

  task automatic checkRegs();
    for (int i = 0; i < 2; i++) begin
      checkOutput("mrst_n", i, 32'(oMrst[i]), 32'(mMrst[i]));
      checkOutput("slot", i, 32'(oSlot[i]), 32'(mSlot[i]));
      checkOutput("tap", i, 32'(oTap[i]), 32'(mTap[i]));
      checkOutput("frame", i, 32'(oFrame[i]), 32'(mFrame[i]));
      checkOutput("sh1", i, 32'(oSh1[i]), 32'(mSh1[i]));
      checkOutput("sh2", i, 32'(oSh2[i]), 32'(mSh2[i]));
      checkOutput("ack", i, 32'(oAck[i]), 32'(mAck[i]));
    end
  endtask

  // Drive one EMUCLK cycle; reset is visible immediately, everything else after the edge.
  task automatic applyStimulus(input bit ic, input bit phiEn, input bit req);
    @(negedge clk);
    icN = ic;
    pcenN = ~phiEn;
    syncReq = req;
    if (!ic) modelReset();
    #1;
    checkComb();
    checkRegs();
    @(posedge clk);
    #1;
    if (ic) modelEdge();
    checkRegs();
  endtask

  function automatic bit rndEn();
    return $urandom_range(0, 2) != 0;
  endfunction

  task automatic runCycles(input int n, input bit ic, input bit req);
    for (int c = 0; c < n; c++) applyStimulus(ic, rndEn(), req);
  endtask

  task automatic runUntilSlotA(input int target, input bit req);
    int n;
    n = 0;
    while (mSlot[0] != target && n < 400) begin
      applyStimulus(1'b1, rndEn(), req);
      n++;
    end
    checks++;
    assert (n < 400) else begin
      failures++;
      $display("[TB] FAIL slotWait[0] observed=%0d expected=%0d", mSlot[0], target);
      $error("[TB] timed out waiting for slot %0d", target);
    end
  endtask

  initial begin
    bit reqState;
    int v;
    modelReset();
    cfgA = '0;
    tapVal[0][0] = 0;  cfgA = opm_set_tap(cfgA, 0, TAP_CYCLE_01);
    tapVal[0][1] = 30; cfgA = opm_set_tap(cfgA, 1, TAP_CYCLE_31);
    tapVal[0][2] = 11; cfgA = opm_set_tap(cfgA, 2, TAP_CYCLE_12_28.first);
    tapVal[0][3] = 27; cfgA = opm_set_tap(cfgA, 3, TAP_CYCLE_12_28.second);
    tapVal[0][4] = 31; cfgA = opm_set_tap(cfgA, 4, 5'd31);
    for (int k = 5; k < 16; k++) begin
      v = int'($urandom_range(0, 31));
      tapVal[0][k] = v;
      cfgA = opm_set_tap(cfgA, k, 5'(v));
    end
    for (int k = 0; k < 16; k++) tapVal[1][k] = 0;
    tapVal[1][0] = 0; tapVal[1][1] = 23; tapVal[1][2] = 30;
    cfgB = {5'd30, 5'd23, 5'd0};

    $display("[TB] reset hold");
    runCycles(8, 1'b0, 1'b0);

    $display("[TB] release and free run");
    runCycles(700, 1'b1, 1'b0);

    $display("[TB] mid-frame reset at slot 17");
    runUntilSlotA(17, 1'b0);
    runCycles(20, 1'b0, 1'b0);
    runCycles(300, 1'b1, 1'b0);

    $display("[TB] resync request at slot 9");
    runUntilSlotA(9, 1'b0);
    runCycles(40, 1'b1, 1'b1);
    runCycles(80, 1'b1, 1'b0);

    $display("[TB] random resync traffic");
    reqState = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) reqState = ~reqState;
      applyStimulus(1'b1, rndEn(), reqState);
    end

    $display("[TB] request held through reset");
    runCycles(10, 1'b0, 1'b1);
    runCycles(200, 1'b1, 1'b1);
    runCycles(60, 1'b1, 1'b0);

    $display("[TB] short reset pulses");
    for (int p = 0; p < 4; p++) begin
      runCycles(int'($urandom_range(1, 3)), 1'b0, 1'b0);
      runCycles(int'($urandom_range(20, 150)), 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ikaopm_slotgen.md
# ikaopm_slotgen

Parametrised slot-timing generator for the FM core. It derives phi1 and its clock enables from the phiM clock enable with a configurable divide ratio, and runs a slot counter with a configurable slot count. It produces configurable slot-decode strobes, SH1/SH2 channel-sample strobes and a frame strobe. It sits at the top of the core and drives every operator/EG/PG/LFO pipeline; it supersedes the fixed 32-slot, divide-by-2 generator.

## Interface
- SLOTS, 32, slots per frame; multiple of 4, 4..256
- SLOT_W, 5, counter width; must satisfy 2^SLOT_W >= SLOTS
- CEN_DIV, 2, phiM enables per phi1 period; even, >= 2
- SYNC_STAGES, 4, reset-release synchroniser depth, >= 2
- SH_DELAY, 5, SH1/SH2 pipeline delay in phi1 cycles, >= 1
- TAP_NUM, 16, number of decode strobes
- i_EMUCLK  in  1  master emulation clock; all flops on rising edge
- i_IC_n  in  1  reset, asynchronous, active-low
- i_phiM_PCEN_n  in  1  phiM positive-edge enable, active-low
- i_TAP_CFG  in  TAP_NUM*SLOT_W  tap k compare value at bits [k*SLOT_W +: SLOT_W]; quasi-static
- i_SYNC_REQ  in  1  frame-resync request (4-phase handshake)
- o_SYNC_ACK  out  1  resync acknowledge
- o_MRST_n  out  1  core internal reset
- o_phi1  out  1  phi1 level (reference only)
- o_phi1_PCEN_n / o_phi1_NCEN_n  out  1  phi1 rising/falling enables, active-low, one EMUCLK wide
- o_SLOT  out  SLOT_W  current slot counter
- o_TAP  out  TAP_NUM  decode strobes
- o_SH1 / o_SH2  out  1  sample-hold strobes
- o_FRAME  out  1  frame strobe

## Operation
- Reset (i_IC_n low) clears every flop immediately. Outputs read: o_MRST_n=0, o_phi1=1, both enables inactive (1), o_SLOT=0, o_TAP=0, o_SH1=o_SH2=0, o_FRAME=0, o_SYNC_ACK=0.
- Release: a synchroniser chain of SYNC_STAGES flops, async-cleared, shifts in 1 on each phiM enable. Phase counter ph and all enables are held until the last stage is 1; that sets `run`.
- Phase: ph counts 0..CEN_DIV-1 on phiM enables while run.
  - o_phi1 = (ph < CEN_DIV/2).
  - PCEN_n is low when the phiM enable is active and ph==CEN_DIV-1.
  - NCEN_n is low when the phiM enable is active and ph==CEN_DIV/2-1.
  - Both enables are combinational from registered ph, run and i_phiM_PCEN_n.
- All logic below updates only on NCEN.
- o_MRST_n <= run.
- Slot counter:
  - Held at 0 while o_MRST_n=0.
  - Otherwise increments and wraps SLOTS-1 -> 0.
- o_TAP[k] <= (o_SLOT == tap k value). A tap value >= SLOTS never fires.
- o_FRAME <= (o_SLOT == SLOTS-1).
- sh1 = slot in [SLOTS/4, SLOTS/2); sh2 = slot >= 3*SLOTS/4. Each passes through a SH_DELAY-stage shift register. The output register is ANDed with o_MRST_n.

## Timing
- Decode latency is one phi1 cycle. A tap with value v is high for exactly the slot period in which o_SLOT == (v+1) mod SLOTS.
- The SH outputs lag the raw decode by SH_DELAY+1 phi1 cycles.
- First o_MRST_n rise: first NCEN after `run`, i.e. SYNC_STAGES phiM enables plus at most CEN_DIV enables after i_IC_n rises.
- Reset asserted mid-frame: every output returns to its reset value in the same EMUCLK edge, with no enable glitch.
- Resync (when enabled):
  - On an NCEN with i_SYNC_REQ=1, o_SYNC_ACK=0 and o_MRST_n=1: the counter loads 0 and o_SYNC_ACK <= 1.
  - o_SYNC_ACK clears on the first NCEN with i_SYNC_REQ=0.
  - A request while o_MRST_n=0 waits.
  - Resync coinciding with the natural wrap behaves identically, and ACK is still given.
  - The decode/SH pipelines are not flushed.

## Configuration
- IKAOPM_SLOTGEN_RESYNC_EN defined: resync handshake as specified above.
- Not defined: i_SYNC_REQ is ignored, o_SYNC_ACK is tied 0, and no handshake flops are built. Ports remain for integration stability.

## Structure
- Package ikaopm_timing_pkg holds:
  - default OPM parameter constants (SLOTS=32, CEN_DIV=2, SH_DELAY=5);
  - named tap-index constants (e.g. TAP_CYCLE_01=0, TAP_CYCLE_31=30, TAP_CYCLE_12_28 pair);
  - a function packing tap constants into the i_TAP_CFG vector.
- Sub-module ikaopm_cen_divider: synchroniser, run flag, ph counter, phi1 and both enables.

## Test plan
- Reset release, defaults: i_IC_n rises. Required: o_MRST_n rises after 4 phiM enables plus at most 2; o_SLOT then sequences 0,1,..,31,0; the enables alternate every phiM enable.
- CEN_DIV=6: PCEN at every 6th phiM enable and NCEN exactly 3 enables after it; o_phi1 high 3 enables, low 3.
- SLOTS=24, tap0=0, tap1=23, tap2=30: o_TAP[0] high in slot 1, o_TAP[1] high in slot 0; o_TAP[2] never fires. o_FRAME high in slot 0. o_SH1 covers slots 6..11 delayed 6 phi1; o_SH2 covers slots 18..23 delayed 6 phi1.
- Mid-frame reset at slot 17: all outputs return to reset values on the same EMUCLK edge; SH never pulses afterwards until re-released.
- Resync with macro, request raised at slot 9: next NCEN sets o_SLOT=0 and o_SYNC_ACK=1; ACK drops one NCEN after the request drops. Without macro: counter is unaffected and ACK stays 0.
- Resync request held through reset: no ACK while o_MRST_n=0; ACK on the first NCEN after o_MRST_n=1.
